uart_serial: RTL and testbench
==============================

UART_SERIAL -- requirements
Module: uart_serial

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16: i_clk cycles per serial bit (even, at least 4).
REQ-002 SHALL have parameter RX_FIFO_DEPTH, default 4: RX FIFO entries (power of two).
REQ-003 SHALL have port i_clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port i_re  in  1  bus read strobe.
REQ-006 SHALL have port i_we  in  1  bus write strobe.
REQ-007 SHALL have port i_addr  in  $clog2(UART_MEM_SIZE)  byte address within the UART window.
REQ-008 SHALL have port i_wdata  in  XLEN  write data.
REQ-009 SHALL have port o_rdata  out  XLEN  read data.
REQ-010 SHALL have port o_meip  out  1  external interrupt request to the core.
REQ-011 SHALL have port i_rx  in  1  asynchronous serial input, idle high.
REQ-012 SHALL have port o_tx  out  1  serial output, idle high.

Function
REQ-013 SHALL decode registers: 0x0 DATA, 0x4 STATUS, 0x8 CTRL; other offsets read 0 and ignore writes.
REQ-014 SHALL drive o_rdata combinationally from i_addr: DATA = zero-extended RX FIFO head byte (0 if empty); STATUS = {rx_frame_err[3], rx_overrun[2], tx_ready[1], rx_valid[0]}; CTRL = {rx_irq_en[0]}.
REQ-015 SHALL pop the RX FIFO at the edge where i_re=1 and i_addr=DATA; popping an empty FIFO changes nothing.
REQ-016 SHALL, on i_we to DATA with tx_ready=1, latch i_wdata[7:0], clear tx_ready at that edge, and begin the start bit in the next cycle.
REQ-017 SHALL ignore DATA writes while tx_ready=0; there is no TX queue.
REQ-018 SHALL clear both sticky flags on any write to STATUS; on a write to CTRL, SHALL load rx_irq_en from i_wdata[0].
REQ-019 SHALL implement the TX FSM IDLE->START->DATA(8 bits, LSB first)->STOP->IDLE, 8N1 framing, each bit held exactly CLKS_PER_BIT cycles; tx_ready SHALL reassert in the cycle after the stop bit ends (frame = 10*CLKS_PER_BIT cycles).
REQ-020 SHALL pass i_rx through a two-flop synchronizer before any use.
REQ-021 SHALL implement the RX FSM IDLE->START->DATA->STOP->IDLE: a falling edge in IDLE starts a timer; the line is sampled at CLKS_PER_BIT/2, then every CLKS_PER_BIT.
REQ-022 SHALL return to IDLE without side effects if the mid-start sample is high (glitch).
REQ-023 SHALL, at the mid-stop sample: if high, push the byte, or, if the FIFO is full, drop it and set rx_overrun; if low, drop the byte and set rx_frame_err.
REQ-024 SHALL, on a push and a pop in the same cycle with the FIFO full, perform both and not flag overrun.
REQ-025 SHALL drive o_meip = rx_irq_en & rx_valid, as a registered-state combination with no extra latency.
REQ-026 SHALL run the RX and TX FSMs independently; full-duplex operation is required.

Reset
REQ-027 SHALL, under i_rst, set o_tx=1, both synchronizer flops to 1, both FSMs to IDLE, FIFO empty, tx_ready=1, sticky flags=0, rx_irq_en=0, and o_meip=0.
REQ-028 SHALL, on reset mid-frame, abort the frame immediately: o_tx high in the next cycle and the partial RX byte discarded.

Structure
REQ-029 SHALL place register offsets, STATUS bit indices, and the uart_tx_state_t/uart_rx_state_t enums in cotm32_pkg.
REQ-030 SHALL place the RX buffer in sub-module uart_fifo (parameterised depth/width, push/pop/full/empty, sync reset).

Verification
REQ-031 SHALL test: reset, write DATA=0x55 -> o_tx low 16 cycles from the next cycle, then bits 1,0,1,0,1,0,1,0, stop high; STATUS.tx_ready=0 for 160 cycles, then 1.
REQ-032 SHALL test: CTRL=1, drive an 0xA3 frame on i_rx -> STATUS=0x3 and o_meip=1; read DATA -> 0x000000A3; o_meip=0 next cycle.
REQ-033 SHALL test: five frames 0x01..0x05 with no reads -> reads return 0x01..0x04 and STATUS bit2=1; writing STATUS clears it.
REQ-034 SHALL test: a frame whose stop bit is 0 -> STATUS=0xA (frame_err, tx_ready), FIFO empty.
REQ-035 SHALL test: i_rx low for 4 cycles -> no push and flags unchanged; then a DATA write while busy -> only the first byte is transmitted.
REQ-036 SHALL test: i_rst asserted mid-TX frame -> o_tx=1 next cycle and STATUS=0x2.

Source files
------------

// File: rtl/cotm32_pkg.sv
// cotm32 shared definitions
// UART register map, status bits, FSM states
package cotm32_pkg;

  localparam int XLEN          = 32;
  localparam int UART_MEM_SIZE = 16;
  localparam int UART_AW       = $clog2(UART_MEM_SIZE);

  localparam logic [UART_AW-1:0] UART_DATA   = 'h0;
  localparam logic [UART_AW-1:0] UART_STATUS = 'h4;
  localparam logic [UART_AW-1:0] UART_CTRL   = 'h8;

  localparam int STS_RX_VALID  = 0;
  localparam int STS_TX_READY  = 1;
  localparam int STS_OVERRUN   = 2;
  localparam int STS_FRAME_ERR = 3;

  localparam int CTRL_IRQ_EN   = 0;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } uart_rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO for received bytes
// Head is visible on o_rdata; DEPTH is a power of two, >= 2
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign o_empty = (wr_ptr == rd_ptr);
  assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | i_pop);
  assign o_rdata = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset
  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= i_wdata;
    end
  end

  // Pointer update, push and pop may coincide
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_serial.sv
// Memory-mapped 8N1 UART with RX FIFO and interrupt
// Full-duplex: TX and RX FSMs run independently
module uart_serial
  import cotm32_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 16,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_re,
  input  logic               i_we,
  input  logic [UART_AW-1:0] i_addr,
  input  logic [XLEN-1:0]    i_wdata,
  output logic [XLEN-1:0]    o_rdata,
  output logic               o_meip,
  input  logic               i_rx,
  output logic               o_tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] MID     = CW'(CLKS_PER_BIT / 2 - 1);

  logic sel_data;
  logic sel_status;
  logic sel_ctrl;

  uart_tx_state_t tx_state, tx_state_d;
  logic [CW-1:0]  tx_cnt, tx_cnt_d;
  logic [2:0]     tx_bit, tx_bit_d;
  logic [7:0]     tx_shift, tx_shift_d;
  logic           tx_line_d;
  logic           tx_ready;
  logic           tx_load;

  uart_rx_state_t rx_state, rx_state_d;
  logic [CW-1:0]  rx_cnt, rx_cnt_d;
  logic [2:0]     rx_bit, rx_bit_d;
  logic [7:0]     rx_shift, rx_shift_d;
  logic           rx_s1;
  logic           rx_s2;
  logic           rx_prev;
  logic           rx_done;
  logic           rx_ferr;

  logic           rx_overrun;
  logic           rx_frame_err;
  logic           rx_irq_en;
  logic           rx_valid;
  logic           rx_pop;
  logic           ovr_set;

  logic [7:0]     fifo_head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           unused_wdata;

  assign unused_wdata = ^i_wdata[XLEN-1:8];

  assign sel_data   = (i_addr == UART_DATA);
  assign sel_status = (i_addr == UART_STATUS);
  assign sel_ctrl   = (i_addr == UART_CTRL);

  assign tx_ready = (tx_state == TX_IDLE);
  assign tx_load  = i_we & sel_data & tx_ready;

  assign rx_valid = ~fifo_empty;
  assign rx_pop   = i_re & sel_data;
  assign ovr_set  = rx_done & fifo_full & ~rx_pop;
  assign o_meip   = rx_irq_en & rx_valid;

  // TX state register; line is registered to stay glitch-free
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      o_tx     <= 1'b1;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      o_tx     <= tx_line_d;
    end
  end

  // TX next state: start, 8 data LSB first, stop
  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt + CW'(1);
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    unique case (tx_state)
      TX_IDLE: begin
        tx_cnt_d = '0;
        if (tx_load) begin
          tx_state_d = TX_START;
          tx_shift_d = i_wdata[7:0];
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_END) begin
          tx_state_d = TX_DATA;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_END) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift[7:1]};
          tx_bit_d   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_d = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_END) begin
          tx_state_d = TX_IDLE;
          tx_cnt_d   = '0;
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        tx_cnt_d   = '0;
      end
    endcase
    tx_line_d = 1'b1;
    if (tx_state_d == TX_START) tx_line_d = 1'b0;
    if (tx_state_d == TX_DATA)  tx_line_d = tx_shift_d[0];
  end

  // RX synchronizer, edge history and FSM state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= i_rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_d;
      rx_cnt   <= rx_cnt_d;
      rx_bit   <= rx_bit_d;
      rx_shift <= rx_shift_d;
    end
  end

  // RX next state: mid-bit sampling after a falling edge
  always_comb begin
    rx_state_d = rx_state;
    rx_cnt_d   = rx_cnt + CW'(1);
    rx_bit_d   = rx_bit;
    rx_shift_d = rx_shift;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev & ~rx_s2) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_cnt == MID) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2 ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s2, rx_shift[7:1]};
          rx_bit_d   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_END) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          rx_done    = rx_s2;
          rx_ferr    = ~rx_s2;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
        rx_cnt_d   = '0;
      end
    endcase
  end

  uart_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (rx_done),
    .i_pop   (rx_pop),
    .i_wdata (rx_shift),
    .o_rdata (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  // Sticky error flags and interrupt enable; a new error beats a clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_irq_en    <= 1'b0;
    end else begin
      if (i_we & sel_status) begin
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
      end
      if (ovr_set) rx_overrun   <= 1'b1;
      if (rx_ferr) rx_frame_err <= 1'b1;
      if (i_we & sel_ctrl) rx_irq_en <= i_wdata[CTRL_IRQ_EN];
    end
  end

  // Combinational read mux
  always_comb begin
    o_rdata = '0;
    unique case (1'b1)
      sel_data: begin
        if (rx_valid) o_rdata[7:0] = fifo_head;
      end
      sel_status: begin
        o_rdata[STS_RX_VALID]  = rx_valid;
        o_rdata[STS_TX_READY]  = tx_ready;
        o_rdata[STS_OVERRUN]   = rx_overrun;
        o_rdata[STS_FRAME_ERR] = rx_frame_err;
      end
      sel_ctrl: begin
        o_rdata[CTRL_IRQ_EN] = rx_irq_en;
      end
      default: o_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_serial.sv
// Directed bench for uart_serial
// Table-driven RX frames plus TX, overrun, glitch and reset sequences
module tb_uart_serial;
  import cotm32_pkg::*;

  localparam int CPB = 16;

  typedef struct {
    logic [7:0]  b;
    logic        stop;
    logic [31:0] exp_status;
    logic [31:0] exp_data;
    logic        exp_meip;
  } rx_vec_t;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_re;
  logic               i_we;
  logic [UART_AW-1:0] i_addr;
  logic [XLEN-1:0]    i_wdata;
  logic [XLEN-1:0]    o_rdata;
  logic               o_meip;
  logic               i_rx;
  logic               o_tx;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 i_clk = ~i_clk;

  uart_serial #(
    .CLKS_PER_BIT  (CPB),
    .RX_FIFO_DEPTH (4)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_re    (i_re),
    .i_we    (i_we),
    .i_addr  (i_addr),
    .i_wdata (i_wdata),
    .o_rdata (o_rdata),
    .o_meip  (o_meip),
    .i_rx    (i_rx),
    .o_tx    (o_tx)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic wr(input logic [UART_AW-1:0] a,
                    input logic [31:0] d);
    i_addr  = a;
    i_wdata = d;
    i_we    = 1'b1;
    @(negedge i_clk);
    i_we    = 1'b0;
  endtask

  task automatic rd(input logic [UART_AW-1:0] a,
                    output logic [31:0] d);
    i_addr = a;
    #1 d = o_rdata;
  endtask

  task automatic pop(output logic [31:0] d);
    i_addr = UART_DATA;
    i_re   = 1'b1;
    #1 d = o_rdata;
    @(negedge i_clk);
    i_re   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    i_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      idle(CPB);
    end
    i_rx = stop;
    idle(CPB);
    i_rx = 1'b1;
    idle(CPB);
  endtask

  rx_vec_t     vecs [5];
  logic [31:0] v;
  logic [9:0]  frame;
  logic [9:0]  got;
  int          tx_bad;
  int          rdy_bad;
  int          lows;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA3, 1'b1, 32'h3, 32'hA3, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 32'h3, 32'h00, 1'b1};
    vecs[2] = '{8'hFF, 1'b1, 32'h3, 32'hFF, 1'b1};
    vecs[3] = '{8'h5A, 1'b0, 32'hA, 32'h00, 1'b0};
    vecs[4] = '{8'h81, 1'b1, 32'h3, 32'h81, 1'b1};

    i_rst = 1'b1; i_re = 1'b0; i_we = 1'b0;
    i_addr = '0; i_wdata = '0; i_rx = 1'b1;
    idle(3);
    i_rst = 1'b0;
    idle(2);

    check("rst_tx", {31'd0, o_tx}, 32'h1);
    check("rst_meip", {31'd0, o_meip}, 32'h0);
    rd(UART_STATUS, v); check("rst_status", v, 32'h2);
    rd(UART_CTRL, v);   check("rst_ctrl", v, 32'h0);
    rd(UART_DATA, v);   check("rst_data", v, 32'h0);
    idle(1);
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'hC, v); check("unmapped", v, 32'h0);
    rd(UART_STATUS, v); check("unmapped_sts", v, 32'h2);
    idle(1);

    frame = {1'b1, 8'h55, 1'b0};
    tx_bad = 0; rdy_bad = 0;
    wr(UART_DATA, 32'h55);
    for (int k = 0; k < 10 * CPB; k++) begin
      rd(UART_STATUS, v);
      if (o_tx !== frame[k / CPB]) tx_bad++;
      if (v[1] !== 1'b0) rdy_bad++;
      @(negedge i_clk);
    end
    check("tx55_line_bad", tx_bad, 0);
    check("tx55_busy_bad", rdy_bad, 0);
    rd(UART_STATUS, v); check("tx55_ready", v, 32'h2);
    check("tx55_idle", {31'd0, o_tx}, 32'h1);
    idle(1);

    wr(UART_CTRL, 32'h1);
    rd(UART_CTRL, v); check("ctrl_set", v, 32'h1);
    idle(1);
    foreach (vecs[i]) begin
      send_frame(vecs[i].b, vecs[i].stop);
      rd(UART_STATUS, v);
      check($sformatf("v%0d_status", i), v, vecs[i].exp_status);
      check($sformatf("v%0d_meip", i), {31'd0, o_meip},
            {31'd0, vecs[i].exp_meip});
      idle(1);
      pop(v);
      check($sformatf("v%0d_data", i), v, vecs[i].exp_data);
      check($sformatf("v%0d_meip_clr", i), {31'd0, o_meip}, 32'h0);
      wr(UART_STATUS, 32'h0);
      rd(UART_STATUS, v);
      check($sformatf("v%0d_sts_clr", i), v, 32'h2);
      idle(1);
    end

    wr(UART_CTRL, 32'h0);
    send_frame(8'h42, 1'b1);
    check("noirq_meip", {31'd0, o_meip}, 32'h0);
    rd(UART_STATUS, v); check("noirq_status", v, 32'h3);
    idle(1);
    pop(v); check("noirq_data", v, 32'h42);

    for (int f = 1; f <= 5; f++) send_frame(8'(f), 1'b1);
    rd(UART_STATUS, v); check("ovr_status", v, 32'h7);
    idle(1);
    for (int f = 1; f <= 4; f++) begin
      pop(v);
      check($sformatf("ovr_data%0d", f), v, 32'(f));
    end
    pop(v); check("ovr_empty", v, 32'h0);
    rd(UART_STATUS, v); check("ovr_sticky", v, 32'h6);
    idle(1);
    wr(UART_STATUS, 32'h0);
    rd(UART_STATUS, v); check("ovr_clear", v, 32'h2);
    idle(1);

    i_rx = 1'b0;
    idle(4);
    i_rx = 1'b1;
    idle(40);
    rd(UART_STATUS, v); check("glitch_status", v, 32'h2);
    idle(1);

    got = '0;
    wr(UART_DATA, 32'h3C);
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k == 20) begin
        i_addr = UART_DATA; i_wdata = 32'hC3; i_we = 1'b1;
      end
      if (k == 21) i_we = 1'b0;
      if (k % CPB == CPB / 2) got[k / CPB] = o_tx;
      @(negedge i_clk);
    end
    check("busy_frame", {22'd0, got}, {22'd0, 1'b1, 8'h3C, 1'b0});
    lows = 0;
    for (int k = 0; k < 12 * CPB; k++) begin
      if (o_tx !== 1'b1) lows++;
      @(negedge i_clk);
    end
    check("busy_no_second", lows, 0);
    rd(UART_STATUS, v); check("busy_ready", v, 32'h2);
    idle(1);

    wr(UART_CTRL, 32'h1);
    wr(UART_DATA, 32'hF0);
    i_rx = 1'b0;
    idle(49);
    check("rstmid_pre_tx", {31'd0, o_tx}, 32'h0);
    i_rst = 1'b1;
    i_rx  = 1'b1;
    @(negedge i_clk);
    check("rstmid_tx", {31'd0, o_tx}, 32'h1);
    i_rst = 1'b0;
    idle(200);
    rd(UART_STATUS, v); check("rstmid_status", v, 32'h2);
    rd(UART_CTRL, v);   check("rstmid_ctrl", v, 32'h0);
    check("rstmid_meip", {31'd0, o_meip}, 32'h0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
